issue_queue_scheduler: RTL and testbench
========================================

ISSUE_QUEUE_SCHEDULER -- requirements
Module: issue_queue_scheduler

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 3, log2 of entry count; SLOTS = 1 << ADDR_WIDTH.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, payload width per entry.
REQ-003 SHALL have parameter TAG_WIDTH, default 6, width of producer tag an entry waits on.
REQ-004 SHALL have port clock  input  1  sole clock, rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have ports alloc_valid input 1, alloc_ready output 1: allocation handshake.
REQ-007 SHALL have ports alloc_data input DATA_WIDTH, alloc_tag input TAG_WIDTH, alloc_src_ready input 1 (operand already available).
REQ-008 SHALL have ports wakeup_valid input 1, wakeup_tag input TAG_WIDTH: producer broadcast.
REQ-009 SHALL have ports issue_valid output 1, issue_ready input 1: issue handshake.
REQ-010 SHALL have ports issue_data output DATA_WIDTH, issue_index output ADDR_WIDTH: selected payload and slot.
REQ-011 SHALL have ports flush input 1, count output ADDR_WIDTH+1, full output 1, empty output 1.

Function
REQ-012 SHALL hold per slot: valid, waiting, tag, data; circular pointers head, tail (ADDR_WIDTH bits, wrap modulo SLOTS); count = occupied span head..tail-1 including holes.
REQ-013 SHALL assert alloc_ready = (count < SLOTS) && !flush; full = (count == SLOTS); empty = (count == 0).
REQ-014 SHALL, on alloc_valid && alloc_ready, write slot[tail]: valid=1, waiting=!alloc_src_ready, tag, data; tail increments, wrapping SLOTS-1 -> 0.
REQ-015 SHALL, on wakeup_valid, clear waiting on every valid slot whose tag equals wakeup_tag, effective next cycle (1-cycle wakeup-to-issue).
REQ-016 SHALL define slot ready = valid && !waiting; search range [head, tail-1] with wrap; when full, all SLOTS slots starting at head.
REQ-017 SHALL drive issue_valid combinationally high when any in-range slot is ready and flush is low; issue_index = ready slot closest to head (oldest first); issue_data = slot[issue_index].data.
REQ-018 SHALL, on issue_valid && issue_ready, clear valid of slot[issue_index] at the clock edge; issue_data/issue_index stable while issue_valid && !issue_ready unless an older slot becomes ready.
REQ-019 SHALL retire at most one slot per cycle: if count > 0 and registered slot[head].valid == 0, head increments (wraps) and count decrements; issue of head slot therefore retires one cycle later.
REQ-020 SHALL, on simultaneous alloc and retire, keep count unchanged; head and tail both advance.
REQ-021 SHALL, on flush, clear all valid bits, set head=tail=count=0 next cycle; flush overrides same-cycle alloc, wakeup and issue (no handshake completes).
REQ-022 SHALL never issue a slot outside the in-range span nor issue any slot twice.

Reset
REQ-023 SHALL, while reset low, asynchronously force head=0, tail=0, count=0, all valid=0, all waiting=0.
REQ-024 SHALL drive after reset: issue_valid=0, alloc_ready=1, empty=1, full=0, count=0; issue_data/issue_index don't-care while issue_valid=0.
REQ-025 SHALL, on reset asserted mid-operation, discard all entries; no issue handshake completes in that cycle.

Configuration
REQ-026 SHALL support macro ISSUE_QUEUE_WAKEUP_BYPASS_EN.
REQ-027 With macro defined: alloc in the same cycle as wakeup_valid with wakeup_tag == alloc_tag SHALL store waiting=0.
REQ-028 Without macro: such entry SHALL store waiting=!alloc_src_ready (same-cycle wakeup missed); producers must not broadcast in the allocation cycle.

Verification
REQ-029 Reset, then alloc 3 entries src_ready=1, issue_ready=1 -> issues indices 0,1,2 in order, one per cycle; count returns to 0, empty=1.
REQ-030 Alloc A(tag 5, waiting), B(ready); issue_ready=1 -> B issues (index 1); wakeup_tag=5 -> A issues next cycle; head stays 0 until A issued, then retires 2 slots over 2 cycles.
REQ-031 ADDR_WIDTH=3: fill 8 entries -> full=1, alloc_ready=0; issue slot 0, retire -> alloc lands at index 0 with head=1; ready slots 7 and 0 -> slot 7 issued first (wrap order).
REQ-032 issue_valid high with issue_ready=0 for 4 cycles -> issue_index/issue_data held, no slot cleared, count unchanged.
REQ-033 Flush with alloc_valid=1 and issue_ready=1, 5 entries present -> next cycle count=0, head=tail=0, issue_valid=0, nothing issued or allocated.
REQ-034 Alloc tag 9 waiting with same-cycle wakeup_tag=9 -> with ISSUE_QUEUE_WAKEUP_BYPASS_EN issue_valid=1 next cycle; without, issue_valid stays 0 until a later wakeup.

Source files
------------

// File: rtl/issue_queue_scheduler_if.sv
// Allocation, wakeup, issue and status bundle for issue_queue_scheduler.
// The scheduler connects through the slave modport and its driver through master.
interface issue_queue_scheduler_if #(
    parameter int ADDR_WIDTH = 3,
    parameter int DATA_WIDTH = 32,
    parameter int TAG_WIDTH  = 6
);
    logic                  alloc_valid;
    logic                  alloc_ready;
    logic [DATA_WIDTH-1:0] alloc_data;
    logic [TAG_WIDTH-1:0]  alloc_tag;
    logic                  alloc_src_ready;
    logic                  wakeup_valid;
    logic [TAG_WIDTH-1:0]  wakeup_tag;
    logic                  issue_valid;
    logic                  issue_ready;
    logic [DATA_WIDTH-1:0] issue_data;
    logic [ADDR_WIDTH-1:0] issue_index;
    logic                  flush;
    logic [ADDR_WIDTH:0]   count;
    logic                  full;
    logic                  empty;

    modport master (
        output alloc_valid, alloc_data, alloc_tag, alloc_src_ready,
        output wakeup_valid, wakeup_tag, issue_ready, flush,
        input  alloc_ready, issue_valid, issue_data, issue_index, count, full, empty
    );

    modport slave (
        input  alloc_valid, alloc_data, alloc_tag, alloc_src_ready,
        input  wakeup_valid, wakeup_tag, issue_ready, flush,
        output alloc_ready, issue_valid, issue_data, issue_index, count, full, empty
    );
endinterface

// File: rtl/issue_queue_scheduler.sv
// Circular issue queue with oldest-ready-first select and in-order retire; latency alloc->issue and wakeup->issue 1 cycle.
// Backpressure: alloc_ready low when full or flushing; issue output held while !issue_ready. Optional: ISSUE_QUEUE_WAKEUP_BYPASS_EN.
module issue_queue_scheduler #(
    parameter int ADDR_WIDTH = 3,
    parameter int DATA_WIDTH = 32,
    parameter int TAG_WIDTH  = 6
) (
    input  logic                  clock,
    input  logic                  reset,
    issue_queue_scheduler_if.slave bus
);
    localparam int SLOTS = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] SLOTS_C = (ADDR_WIDTH+1)'(SLOTS);

    logic [SLOTS-1:0]      valid_q;
    logic [SLOTS-1:0]      waiting_q;
    logic [TAG_WIDTH-1:0]  tag_q  [SLOTS];
    logic [DATA_WIDTH-1:0] data_q [SLOTS];
    logic [ADDR_WIDTH-1:0] head_q;
    logic [ADDR_WIDTH-1:0] tail_q;
    logic [ADDR_WIDTH:0]   count_q;

    logic                  found;
    logic [ADDR_WIDTH-1:0] sel;
    logic [ADDR_WIDTH-1:0] slot;
    logic                  alloc_fire;
    logic                  issue_fire;
    logic                  retire;
    logic                  alloc_waiting;

    // Walk outward from head so the first ready hit is the oldest entry.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        slot  = '0;
        for (int i = 0; i < SLOTS; i++) begin
            slot = head_q + ADDR_WIDTH'(i);
            if (!found && ((ADDR_WIDTH+1)'(i) < count_q) && valid_q[slot] && !waiting_q[slot]) begin
                found = 1'b1;
                sel   = slot;
            end
        end
    end

    assign bus.alloc_ready = (count_q < SLOTS_C) && !bus.flush;
    assign bus.full        = (count_q == SLOTS_C);
    assign bus.empty       = (count_q == '0);
    assign bus.count       = count_q;
    assign bus.issue_valid = found && !bus.flush;
    assign bus.issue_index = sel;
    assign bus.issue_data  = data_q[sel];

    assign alloc_fire = bus.alloc_valid && bus.alloc_ready;
    assign issue_fire = bus.issue_valid && bus.issue_ready;
    assign retire     = (count_q != '0) && !valid_q[head_q];

`ifdef ISSUE_QUEUE_WAKEUP_BYPASS_EN
    assign alloc_waiting = !bus.alloc_src_ready &&
                           !(bus.wakeup_valid && (bus.wakeup_tag == bus.alloc_tag));
`else
    assign alloc_waiting = !bus.alloc_src_ready;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valid_q   <= '0;
            waiting_q <= '0;
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
        end else if (bus.flush) begin
            valid_q   <= '0;
            waiting_q <= '0;
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
        end else begin
            for (int i = 0; i < SLOTS; i++) begin
                if (bus.wakeup_valid && valid_q[i] && (tag_q[i] == bus.wakeup_tag))
                    waiting_q[i] <= 1'b0;
            end
            // The tail slot is never valid while allocatable, so it cannot collide with sel.
            if (issue_fire)
                valid_q[sel] <= 1'b0;
            if (alloc_fire) begin
                valid_q[tail_q]   <= 1'b1;
                waiting_q[tail_q] <= alloc_waiting;
                tail_q            <= tail_q + 1'b1;
            end
            if (retire)
                head_q <= head_q + 1'b1;
            if (alloc_fire && !retire)
                count_q <= count_q + 1'b1;
            else if (!alloc_fire && retire)
                count_q <= count_q - 1'b1;
        end
    end

    // Payload needs no reset: it is only observed through a valid slot.
    always_ff @(posedge clock) begin
        if (alloc_fire) begin
            data_q[tail_q] <= bus.alloc_data;
            tag_q[tail_q]  <= bus.alloc_tag;
        end
    end
endmodule

// File: tb/tb_issue_queue_scheduler.sv
// Scoreboard bench for issue_queue_scheduler: expected issues queued at stimulus time, compared on each issue handshake.
module tb_issue_queue_scheduler;
    localparam int AW = 3;
    localparam int DW = 32;
    localparam int TW = 6;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    issue_queue_scheduler_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TAG_WIDTH(TW)) bus ();

    issue_queue_scheduler #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TAG_WIDTH(TW)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic [AW-1:0] idx;
        logic [DW-1:0] dat;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_chk  = 0;
    int   n_pass = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    always @(negedge clock) begin
        if (reset && bus.issue_valid && bus.issue_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_issue", 64'(bus.issue_valid), 64'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("issue_idx", 64'(bus.issue_index), 64'(mon_e.idx));
                check("issue_dat", 64'(bus.issue_data), 64'(mon_e.dat));
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        bus.alloc_valid     = 1'b0;
        bus.alloc_data      = '0;
        bus.alloc_tag       = '0;
        bus.alloc_src_ready = 1'b0;
        bus.wakeup_valid    = 1'b0;
        bus.wakeup_tag      = '0;
        bus.issue_ready     = 1'b0;
        bus.flush           = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b0;
        step();
        step();
        reset = 1'b1;
    endtask

    task automatic push(input int idx, input logic [DW-1:0] dat);
        exp_t e;
        e.idx = AW'(idx);
        e.dat = dat;
        exp_q.push_back(e);
    endtask

    task automatic alloc(input logic [DW-1:0] d, input int t, input logic rdy);
        bus.alloc_valid     = 1'b1;
        bus.alloc_data      = d;
        bus.alloc_tag       = TW'(t);
        bus.alloc_src_ready = rdy;
        step();
        bus.alloc_valid     = 1'b0;
    endtask

    task automatic wakeup(input int t);
        bus.wakeup_valid = 1'b1;
        bus.wakeup_tag   = TW'(t);
        step();
        bus.wakeup_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) step();
        check(tag, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // Reset state
        do_reset();
        check("rst_issue_valid", 64'(bus.issue_valid), 64'd0);
        check("rst_alloc_ready", 64'(bus.alloc_ready), 64'd1);
        check("rst_empty", 64'(bus.empty), 64'd1);
        check("rst_full", 64'(bus.full), 64'd0);
        check("rst_count", 64'(bus.count), 64'd0);

        // Three ready entries issue in order, one per cycle
        bus.issue_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            push(i, 32'hA000_0000 + DW'(i));
            alloc(32'hA000_0000 + DW'(i), i, 1'b1);
        end
        repeat (4) step();
        check("s1_count", 64'(bus.count), 64'd0);
        check("s1_empty", 64'(bus.empty), 64'd1);
        drain("s1_drain");

        // Younger ready entry bypasses an older waiting one
        do_reset();
        bus.issue_ready = 1'b1;
        push(1, 32'hB000_000B);
        alloc(32'hB000_000A, 5, 1'b0);
        alloc(32'hB000_000B, 7, 1'b1);
        repeat (3) step();
        check("s2_hold_count", 64'(bus.count), 64'd2);
        check("s2_no_issue", 64'(bus.issue_valid), 64'd0);
        push(0, 32'hB000_000A);
        wakeup(5);
        check("s2_wake_valid", 64'(bus.issue_valid), 64'd1);
        step();
        check("s2_count_a", 64'(bus.count), 64'd2);
        step();
        check("s2_count_b", 64'(bus.count), 64'd1);
        step();
        check("s2_count_c", 64'(bus.count), 64'd0);
        check("s2_empty", 64'(bus.empty), 64'd1);
        drain("s2_drain");

        // Full queue, wrap-around allocation and wrap-order select
        do_reset();
        for (int i = 0; i < 8; i++) alloc(32'hC000_0000 + DW'(i), 10 + i, 1'b0);
        check("s3_full", 64'(bus.full), 64'd1);
        check("s3_alloc_ready", 64'(bus.alloc_ready), 64'd0);
        check("s3_count8", 64'(bus.count), 64'd8);
        push(0, 32'hC000_0000);
        bus.issue_ready = 1'b1;
        wakeup(10);
        step();
        bus.issue_ready = 1'b0;
        step();
        check("s3_count7", 64'(bus.count), 64'd7);
        check("s3_not_full", 64'(bus.full), 64'd0);
        check("s3_ready_again", 64'(bus.alloc_ready), 64'd1);
        alloc(32'hC000_00EE, 17, 1'b0);
        check("s3_refill", 64'(bus.count), 64'd8);
        wakeup(17);
        check("s3_wrap_idx", 64'(bus.issue_index), 64'd7);
        push(7, 32'hC000_0007);
        push(0, 32'hC000_00EE);
        bus.issue_ready = 1'b1;
        drain("s3_drain");
        repeat (3) step();
        check("s3_final_count", 64'(bus.count), 64'd8);

        // Issue held under backpressure
        do_reset();
        alloc(32'hD000_0040, 1, 1'b1);
        alloc(32'hD000_0041, 2, 1'b1);
        for (int k = 0; k < 4; k++) begin
            check("s4_hold_idx", 64'(bus.issue_index), 64'd0);
            check("s4_hold_dat", 64'(bus.issue_data), 64'hD000_0040);
            check("s4_hold_count", 64'(bus.count), 64'd2);
            step();
        end
        push(0, 32'hD000_0040);
        push(1, 32'hD000_0041);
        bus.issue_ready = 1'b1;
        drain("s4_drain");
        repeat (2) step();
        check("s4_count", 64'(bus.count), 64'd0);

        // Flush overrides alloc and issue
        do_reset();
        for (int i = 0; i < 5; i++) alloc(32'hE000_0000 + DW'(i), i, 1'b1);
        check("s5_count5", 64'(bus.count), 64'd5);
        bus.flush           = 1'b1;
        bus.alloc_valid     = 1'b1;
        bus.alloc_data      = 32'hE000_00FF;
        bus.alloc_src_ready = 1'b1;
        bus.issue_ready     = 1'b1;
        #1;
        check("s5_flush_iv", 64'(bus.issue_valid), 64'd0);
        check("s5_flush_ar", 64'(bus.alloc_ready), 64'd0);
        step();
        bus.flush       = 1'b0;
        bus.alloc_valid = 1'b0;
        check("s5_count0", 64'(bus.count), 64'd0);
        check("s5_empty", 64'(bus.empty), 64'd1);
        check("s5_iv0", 64'(bus.issue_valid), 64'd0);
        push(0, 32'hE000_0077);
        alloc(32'hE000_0077, 3, 1'b1);
        drain("s5_drain");

        // Same-cycle wakeup on allocation
        do_reset();
        bus.issue_ready  = 1'b1;
        bus.wakeup_valid = 1'b1;
        bus.wakeup_tag   = TW'(9);
        alloc(32'hF000_0009, 9, 1'b0);
        bus.wakeup_valid = 1'b0;
`ifdef ISSUE_QUEUE_WAKEUP_BYPASS_EN
        push(0, 32'hF000_0009);
        check("s6_bypass_iv", 64'(bus.issue_valid), 64'd1);
`else
        check("s6_nobypass_iv", 64'(bus.issue_valid), 64'd0);
        repeat (2) step();
        check("s6_still_wait", 64'(bus.issue_valid), 64'd0);
        push(0, 32'hF000_0009);
        wakeup(9);
        check("s6_late_wake", 64'(bus.issue_valid), 64'd1);
`endif
        drain("s6_drain");

        // Asynchronous reset mid-operation discards entries
        do_reset();
        for (int i = 0; i < 3; i++) alloc(32'h1000_0000 + DW'(i), i, 1'b1);
        #2 reset = 1'b0;
        #1;
        check("s7_count", 64'(bus.count), 64'd0);
        check("s7_empty", 64'(bus.empty), 64'd1);
        check("s7_iv", 64'(bus.issue_valid), 64'd0);
        step();
        reset = 1'b1;
        bus.issue_ready = 1'b1;
        repeat (2) step();
        check("s7_post_iv", 64'(bus.issue_valid), 64'd0);
        drain("s7_drain");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
